// File: rtl/counter_updown_mod_pkg.sv
// Shared types for the up/down modulo counter: per-cycle request decode.
package counter_updown_mod_pkg;

  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_LOAD,
    REQ_HOLD,
    REQ_UP,
    REQ_DOWN
  } req_e;

  function automatic req_e decode_req(input logic load, input logic inc, input logic dec);
    if (load)            return REQ_LOAD;
    else if (inc && dec) return REQ_HOLD;
    else if (inc)        return REQ_UP;
    else if (dec)        return REQ_DOWN;
    else                 return REQ_NONE;
  endfunction

endpackage

// File: rtl/counter_updown_mod_edge_detect.sv
// Rising-edge one-shot: pulse is high for the cycle in which level first goes high.
module edge_detect_rise (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) level_prev <= 1'b0;
    else        level_prev <= level;
  end

  // Combinational from the live input so the front end adds no latency.
  assign pulse = level & ~level_prev;

endmodule

// File: rtl/counter_updown_mod.sv
// Up/down modulo-N counter with clamped load, wrap/saturate bounds, terminal pulse
// and sticky overflow/underflow flags; optional rising-edge request qualification.
module counter_updown_mod
  import counter_updown_mod_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MODULUS   = 256,
  parameter int unsigned EDGE_MODE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             increment,
  input  logic             decrement,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             saturate,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("counter_updown_mod: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  logic inc_q;
  logic dec_q;

  if (EDGE_MODE != 0) begin : g_edge
    edge_detect_rise u_inc_edge (
      .clock (clock),
      .reset (reset),
      .level (increment),
      .pulse (inc_q)
    );
    edge_detect_rise u_dec_edge (
      .clock (clock),
      .reset (reset),
      .level (decrement),
      .pulse (dec_q)
    );
  end else begin : g_level
    assign inc_q = increment;
    assign dec_q = decrement;
  end

  req_e             req;
  logic [WIDTH-1:0] count_next;
  logic             terminal_next;
  logic             ovf_set;
  logic             unf_set;
  logic [WIDTH-1:0] load_clamped;

  // Clamp compare is one bit wider so load_value never truncates against MAX_COUNT.
  assign load_clamped = ({1'b0, load_value} > {1'b0, MAX_COUNT}) ? MAX_COUNT : load_value;

  always_comb begin
    req           = decode_req(load, inc_q, dec_q);
    count_next    = count;
    terminal_next = 1'b0;
    ovf_set       = 1'b0;
    unf_set       = 1'b0;
    case (req)
      REQ_LOAD: count_next = load_clamped;
      REQ_UP: begin
        if (count < MAX_COUNT) begin
          count_next = count + 1'b1;
        end else begin
          count_next    = saturate ? MAX_COUNT : '0;
          terminal_next = 1'b1;
          ovf_set       = 1'b1;
        end
      end
      REQ_DOWN: begin
        if (count != '0) begin
          count_next = count - 1'b1;
        end else begin
          count_next    = saturate ? '0 : MAX_COUNT;
          terminal_next = 1'b1;
          unf_set       = 1'b1;
        end
      end
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      terminal  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_next;
      terminal  <= terminal_next;
      overflow  <= ovf_set | (overflow & ~clear_flags);
      underflow <= unf_set | (underflow & ~clear_flags);
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench: driver pushes hand-computed expectations, monitor pops and compares.
module tb_counter_updown_mod;

  logic       clk;
  logic       rst_n;
  logic       inc_a, dec_a, load_a, sat_a, clr_a;
  logic [3:0] lv_a;
  logic       inc_b;
  logic       zero;
  logic [3:0] zero4;

  logic [3:0] cnt_a, cnt_b;
  logic       term_a, ovf_a, unf_a;
  logic       term_b, ovf_b, unf_b;

  typedef struct {
    int unsigned dut;
    logic [3:0]  cnt;
    logic        term;
    logic        ovf;
    logic        unf;
    string       name;
  } exp_t;

  exp_t q[$];
  int   compared;
  int   mismatched;

  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .EDGE_MODE(0)) u_dut_a (
    .clock       (clk),
    .reset       (rst_n),
    .increment   (inc_a),
    .decrement   (dec_a),
    .load        (load_a),
    .load_value  (lv_a),
    .saturate    (sat_a),
    .clear_flags (clr_a),
    .count       (cnt_a),
    .terminal    (term_a),
    .overflow    (ovf_a),
    .underflow   (unf_a)
  );

  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .EDGE_MODE(1)) u_dut_b (
    .clock       (clk),
    .reset       (rst_n),
    .increment   (inc_b),
    .decrement   (zero),
    .load        (zero),
    .load_value  (zero4),
    .saturate    (zero),
    .clear_flags (zero),
    .count       (cnt_b),
    .terminal    (term_b),
    .overflow    (ovf_b),
    .underflow   (unf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_now(input int unsigned dut, input logic [3:0] ecnt, input logic eterm,
                           input logic eovf, input logic eunf, input string name);
    logic [3:0] c;
    logic       t, o, u;
    if (dut == 0) begin c = cnt_a; t = term_a; o = ovf_a; u = unf_a; end
    else          begin c = cnt_b; t = term_b; o = ovf_b; u = unf_b; end
    compared++;
    if (c !== ecnt || t !== eterm || o !== eovf || u !== eunf) begin
      mismatched++;
      $display("FAIL %s: got cnt=%0d term=%b ovf=%b unf=%b, want cnt=%0d term=%b ovf=%b unf=%b",
               name, c, t, o, u, ecnt, eterm, eovf, eunf);
    end
  endtask

  // Monitor: outputs settle 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        check_now(e.dut, e.cnt, e.term, e.ovf, e.unf, e.name);
      end
    end
  end

  task automatic step_a(input logic inc, input logic dec, input logic ld, input logic [3:0] lv,
                        input logic sat, input logic clr, input logic [3:0] ecnt,
                        input logic eterm, input logic eovf, input logic eunf, input string name);
    inc_a = inc; dec_a = dec; load_a = ld; lv_a = lv; sat_a = sat; clr_a = clr;
    q.push_back('{0, ecnt, eterm, eovf, eunf, name});
    @(negedge clk);
  endtask

  task automatic step_b(input logic inc, input logic [3:0] ecnt, input logic eterm, input string name);
    inc_b = inc;
    q.push_back('{1, ecnt, eterm, 1'b0, 1'b0, name});
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inc_a = 0; dec_a = 0; load_a = 0; lv_a = '0; sat_a = 0; clr_a = 0; inc_b = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    compared = 0; mismatched = 0;
    zero = 1'b0; zero4 = '0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_now(0, 4'd0, 0, 0, 0, "reset_a");
    check_now(1, 4'd0, 0, 0, 0, "reset_b");
    rst_n = 1'b1;
    @(negedge clk);

    // Level increment across the 9->0 wrap.
    for (int i = 1; i <= 12; i++)
      step_a(1, 0, 0, 4'd0, 0, 0, 4'(i % 10), (i == 10), (i >= 10), 0, $sformatf("inc_run_%0d", i));

    // Saturated decrement at zero, then flag clear.
    step_a(0, 0, 1, 4'd0, 0, 0, 4'd0, 0, 1, 0, "load0");
    for (int i = 0; i < 3; i++)
      step_a(0, 1, 0, 4'd0, 1, 0, 4'd0, 1, 1, 1, $sformatf("dec_sat_%0d", i));
    step_a(0, 0, 0, 4'd0, 0, 1, 4'd0, 0, 0, 0, "clear_flags");

    // Load clamp beats increment, then wrap from the clamped max.
    step_a(1, 0, 1, 4'd13, 0, 0, 4'd9, 0, 0, 0, "load_clamp");
    step_a(1, 0, 0, 4'd0, 0, 0, 4'd0, 1, 1, 0, "wrap_after_clamp");

    // Simultaneous inc/dec holds; set beats clear at a boundary.
    step_a(0, 0, 1, 4'd5, 0, 0, 4'd5, 0, 1, 0, "load5");
    step_a(1, 1, 0, 4'd0, 0, 0, 4'd5, 0, 1, 0, "inc_dec_hold");
    step_a(0, 0, 1, 4'd9, 0, 0, 4'd9, 0, 1, 0, "load9");
    step_a(1, 0, 0, 4'd0, 0, 1, 4'd0, 1, 1, 0, "set_beats_clear");
    step_a(0, 0, 0, 4'd0, 0, 1, 4'd0, 0, 0, 0, "clear_no_event");

    // Saturate at max re-pulses; normal decrement; underflow wrap.
    step_a(0, 0, 1, 4'd9, 0, 0, 4'd9, 0, 0, 0, "load9b");
    step_a(1, 0, 0, 4'd0, 1, 0, 4'd9, 1, 1, 0, "inc_sat_0");
    step_a(1, 0, 0, 4'd0, 1, 0, 4'd9, 1, 1, 0, "inc_sat_1");
    step_a(0, 1, 0, 4'd0, 0, 0, 4'd8, 0, 1, 0, "dec_normal");
    step_a(0, 0, 1, 4'd0, 0, 0, 4'd0, 0, 1, 0, "load0b");
    step_a(0, 1, 0, 4'd0, 0, 0, 4'd9, 1, 1, 1, "dec_wrap");
    step_a(0, 0, 1, 4'd7, 0, 0, 4'd7, 0, 1, 1, "load7");

    // Asynchronous reset between edges.
    idle_inputs();
    #2 rst_n = 1'b0;
    #1 check_now(0, 4'd0, 0, 0, 0, "async_reset");
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_now(0, 4'd0, 0, 0, 0, "post_reset_idle");
    step_a(1, 0, 0, 4'd0, 0, 0, 4'd1, 0, 0, 0, "inc_after_reset");
    idle_inputs();
    @(negedge clk);

    // Edge-qualified increments on the second instance.
    step_b(1, 4'd1, 0, "edge_first");
    for (int i = 0; i < 19; i++) step_b(1, 4'd1, 0, $sformatf("edge_held_%0d", i));
    step_b(0, 4'd1, 0, "edge_low_0");
    step_b(0, 4'd1, 0, "edge_low_1");
    step_b(1, 4'd2, 0, "edge_second");
    step_b(1, 4'd2, 0, "edge_second_held");
    idle_inputs();
    @(negedge clk);

    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
Parametrised successor to the lab's 8-bit up-counter. It is an up/down modulo-N counter with synchronous load, wrap or saturate mode, a terminal-count pulse and sticky overflow/underflow flags. An optional edge-detect front end lets raw level inputs, such as debounced buttons on the NEXYS A7, advance the count once per press. It drives display or compare logic downstream.

Parameters:
WIDTH, 8, bit width of count and load_value.
MODULUS, 256, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2^WIDTH (elaboration error otherwise).
EDGE_MODE, 0, 0: increment/decrement are level-qualified enables, acted on every cycle high; 1: acted on only on the cycle of their rising edge.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
increment  in  1  count up request
decrement  in  1  count down request
load  in  1  synchronous load request
load_value  in  WIDTH  value loaded when load=1
saturate  in  1  0: wrap at bounds; 1: hold at bounds
clear_flags  in  1  synchronous clear of sticky flags
count  out  WIDTH  current count, registered
terminal  out  1  one-cycle pulse on boundary event, registered
overflow  out  1  sticky: an up-step was attempted at MODULUS-1
underflow  out  1  sticky: a down-step was attempted at 0

Behaviour:
- Reset (reset=0, async): count=0, terminal=0, overflow=0, underflow=0, edge-detect history=0.
- All updates occur on the rising clock edge with 1-cycle latency from request to count/terminal.
- Effective requests:
  - EDGE_MODE=0: inc_q=increment, dec_q=decrement.
  - EDGE_MODE=1: inc_q=increment & ~increment_prev, dec_q likewise. History registers update every cycle. The pulse is combinational from the current input, so no added latency.
- Priority, per cycle:
  1. load=1: count <= min(load_value, MODULUS-1). terminal <= 0. Flags unaffected. inc/dec ignored.
  2. inc_q & dec_q: count held, terminal <= 0.
  3. inc_q only:
     - If count < MODULUS-1: count+1.
     - If count == MODULUS-1: saturate=0 gives count <= 0; saturate=1 holds MODULUS-1. In both cases terminal <= 1 and overflow <= 1.
  4. dec_q only:
     - If count > 0: count-1.
     - If count == 0: saturate=0 gives count <= MODULUS-1; saturate=1 holds 0. In both cases terminal <= 1 and underflow <= 1.
  5. None of the above: count held, terminal <= 0.
- terminal is high for exactly one cycle per boundary event. A level-held increment in saturate mode at max re-pulses every cycle when EDGE_MODE=0.
- clear_flags=1 clears overflow and underflow. If a new boundary event occurs in the same cycle, the set wins.
- Arithmetic:
  - Internal compare against MODULUS-1 is done at WIDTH bits.
  - With MODULUS = 2^WIDTH, natural rollover must equal the mod behaviour.
  - load_value clamp compares at WIDTH+1 bits to avoid truncation.
- saturate is sampled each cycle; changing it mid-count affects only the next boundary event.
- Reset asserted mid-operation clears everything immediately, independent of clock. Deassertion resumes counting from 0 on the next qualifying edge.

Decomposition:
- Shared package: none required. Local constants MAX_COUNT = MODULUS-1 (WIDTH bits) and the elaboration-time MODULUS range check live in the module.
- One sub-module: edge_detect_rise, a 1-bit rising-edge one-shot. Ports: clock, reset (async, active-low), level, pulse.
  - Two instances, generated only when EDGE_MODE=1.
  - Reusable for other button-driven labs.

Test Plan:
1. WIDTH=4, MODULUS=10, saturate=0, EDGE_MODE=0: reset then increment high 12 cycles -> count 1..9,0,1,2; terminal pulses once on the 9->0 cycle; overflow=1 after.
2. Same config, count=0, saturate=1, decrement high 3 cycles -> count stays 0; terminal high all 3 cycles; underflow=1. Then clear_flags for 1 cycle -> underflow=0.
3. load=1 with load_value=13 while increment=1 -> count=9 (clamped), terminal=0. Next cycle with load=0, increment=1, saturate=0 -> count=0, terminal=1.
4. increment=decrement=1 at count=5 -> count stays 5, no terminal. clear_flags=1 coincident with overflow event at count=9 -> overflow remains 1.
5. EDGE_MODE=1, increment held high 20 cycles then low 2, then high again -> count advances by exactly 1 per rising edge: 0->1, later 1->2.
6. Assert reset asynchronously between clock edges at count=7 with overflow=1 -> count=0, flags=0 immediately. After release, increment=1 -> count=1 on next edge.
